// File: rtl/mips150_lsu_pkg.sv
// Shared definitions for the MIPS150 load/store unit: FSM states, access-size codes,
// opcode values and the load/store/unsigned decode helpers.
package mips150_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_unsigned(input logic [5:0] op);
        return op inside {OP_LBU, OP_LHU};
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mips150_lsu_extract.sv
// Combinational lane select and sign/zero extension of a loaded byte, half or word.
// Shared with the IO load path.
module mips150_lsu_extract
    import mips150_lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]            rdata,
    input  logic [$clog2(DWIDTH/8)-1:0]  off,
    input  logic [1:0]                   size,
    input  logic                         zero_ext,
    output logic [DWIDTH-1:0]            data
);

    logic [DWIDTH-1:0] lane;
    logic [DWIDTH-1:0] word_ext;

    assign lane = rdata >> {off, 3'b000};

    // Words only need extending on wide datapaths; LW always sign-extends there.
    generate
        if (DWIDTH > 32) begin : g_wide
            assign word_ext = {{(DWIDTH-32){lane[31]}}, lane[31:0]};
        end else begin : g_narrow
            assign word_ext = lane;
        end
    endgenerate

    always_comb begin
        data = word_ext;
        case (size)
            SZ_B: data = zero_ext ? {{(DWIDTH-8){1'b0}}, lane[7:0]}
                                  : {{(DWIDTH-8){lane[7]}}, lane[7:0]};
            SZ_H: data = zero_ext ? {{(DWIDTH-16){1'b0}}, lane[15:0]}
                                  : {{(DWIDTH-16){lane[15]}}, lane[15:0]};
            default: data = word_ext;
        endcase
    end

endmodule

// File: rtl/mips150_lsu.sv
// Multi-cycle load/store unit: one request per handshake, lane-aligned memory access,
// extended load writeback pulse. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module mips150_lsu
    import mips150_lsu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RDW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_opcode,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic [DWIDTH-1:0]     req_wdata,
    input  logic [RDW-1:0]        req_rd,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH/8-1:0]   mem_we,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DWIDTH-1:0]     mem_rdata,
    output logic                  resp_valid,
    output logic                  resp_regwrite,
    output logic [RDW-1:0]        resp_rd,
    output logic [DWIDTH-1:0]     resp_data,
    output logic                  resp_err
);

    localparam int NB = DWIDTH / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t state, state_next;

    logic              r_load;
    logic              r_zext;
    logic              r_err;
    logic [1:0]        r_size;
    logic [OW-1:0]     r_off;
    logic [AWIDTH-1:0] r_addr;
    logic [NB-1:0]     r_we;
    logic [DWIDTH-1:0] r_mdata;
    logic [RDW-1:0]    r_rd;
    logic [DWIDTH-1:0] r_data;

    logic              accept;
    logic              capture;
    logic [1:0]        acc_size;
    logic [OW-1:0]     acc_off;
    logic [OW-1:0]     align_mask;
    logic              acc_err;
    logic [NB-1:0]     acc_we;
    logic [DWIDTH-1:0] acc_mdata;
    logic [DWIDTH-1:0] ext_data;

    assign acc_size = op_size(req_opcode);
    assign acc_off  = req_addr[OW-1:0] & align_mask;

    // Decode of the incoming request: aligned offset, lane enables, replicated data.
    always_comb begin
        align_mask = '1;
        acc_we     = '0;
        acc_mdata  = {(NB/4){req_wdata[31:0]}};
        case (acc_size)
            SZ_B: begin
                acc_mdata = {NB{req_wdata[7:0]}};
                acc_we    = NB'(1) << acc_off;
            end
            SZ_H: begin
                align_mask = ~OW'(1);
                acc_mdata  = {(NB/2){req_wdata[15:0]}};
                acc_we     = NB'(3) << acc_off;
            end
            default: begin
                align_mask = ~OW'(3);
                acc_we     = NB'(15) << acc_off;
            end
        endcase
        if (!is_store(req_opcode)) begin
            acc_we = '0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic acc_misaligned;
    assign acc_misaligned = ((acc_size == SZ_H) && req_addr[0]) ||
                            ((acc_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign acc_err = !(is_load(req_opcode) || is_store(req_opcode)) || acc_misaligned;
`else
    assign acc_err = !(is_load(req_opcode) || is_store(req_opcode));
`endif

    mips150_lsu_extract #(
        .DWIDTH (DWIDTH)
    ) u_extract (
        .rdata    (mem_rdata),
        .off      (r_off),
        .size     (r_size),
        .zero_ext (r_zext),
        .data     (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load  <= 1'b0;
            r_zext  <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= SZ_B;
            r_off   <= '0;
            r_addr  <= '0;
            r_we    <= '0;
            r_mdata <= '0;
            r_rd    <= '0;
            r_data  <= '0;
        end else if (accept) begin
            r_load  <= is_load(req_opcode);
            r_zext  <= is_unsigned(req_opcode);
            r_err   <= acc_err;
            r_size  <= acc_size;
            r_off   <= acc_off;
            r_addr  <= {req_addr[AWIDTH-1:OW], {OW{1'b0}}};
            r_we    <= acc_we;
            r_mdata <= acc_mdata;
            r_rd    <= req_rd;
            r_data  <= '0;
        end else if (capture) begin
            r_data  <= ext_data;
        end
    end

    // Memory outputs exist only in ISSUE and response outputs only in RESP.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        capture       = 1'b0;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_we        = '0;
        mem_wdata     = '0;
        resp_valid    = 1'b0;
        resp_regwrite = 1'b0;
        resp_rd       = '0;
        resp_data     = '0;
        resp_err      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = acc_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_addr      = r_addr;
                mem_we        = r_we;
                mem_wdata     = r_mdata;
                if (mem_req_ready) begin
                    if (!r_load) begin
                        state_next = ST_RESP;
                    end else if (mem_rvalid) begin
                        capture    = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid    = 1'b1;
                resp_regwrite = r_load && !r_err && (r_rd != '0);
                resp_rd       = r_rd;
                resp_data     = r_data;
                resp_err      = r_err;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
